// File: rtl/counter_arb_pkg.sv
// counter_arb_pkg: shared widths, default timeout and FSM state encoding for the counter read arbiter
package counter_arb_pkg;
  localparam int DATABUS_W = 32;
  localparam int COUNTLEN_W = 64;
  localparam int TIMEOUT_DEF = 15;
  typedef enum logic [2:0] {IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, RESP} state_t;
endpackage

// File: rtl/counter_read_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker (req, ptr -> one-hot grant, grant index idx, any-valid valid)
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        grant = '0;
        grant[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
  assign valid = |req;
endmodule

// File: rtl/counter_read_arbiter.sv
// counter_read_arbiter: round-robin arbiter giving NREQ requesters coherent 64-bit snapshots via a two-beat (atomic lo, then hi) 32-bit counter read port
module counter_read_arbiter
  import counter_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DATABUS = DATABUS_W,
  parameter int COUNTLEN = COUNTLEN_W,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_i,
  output logic [NREQ-1:0]     rsp_valid_o,
  output logic [COUNTLEN-1:0] rsp_data_o,
  output logic                rsp_err_o,
  output logic                ctr_req_o,
  output logic                ctr_atomic_o,
  input  logic                ctr_ack_i,
  input  logic [DATABUS-1:0]  ctr_data_i,
  output logic                busy_o
);
  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  if (COUNTLEN != 2 * DATABUS) begin : g_bad_width
    $error("COUNTLEN must equal 2*DATABUS");
  end
  state_t state, state_n;
  logic [NREQ-1:0] grant, pick_grant;
  logic [IW-1:0] gidx, pick_idx, rr;
  logic [DATABUS-1:0] lo, hi;
  logic [TW-1:0] timer;
  logic err, any, tmo, waiting;
  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req(req_i),
    .ptr(rr),
    .grant(pick_grant),
    .idx(pick_idx),
    .valid(any)
  );
  assign tmo = timer == TW'(TIMEOUT - 1);
  assign waiting = state == WAIT_LO || state == WAIT_HI;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = any ? ISSUE_LO : IDLE;
      ISSUE_LO: state_n = WAIT_LO;
      WAIT_LO:  state_n = ctr_ack_i ? ISSUE_HI : tmo ? RESP : WAIT_LO;
      ISSUE_HI: state_n = WAIT_HI;
      WAIT_HI:  state_n = (ctr_ack_i || tmo) ? RESP : WAIT_HI;
      RESP:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    ctr_req_o = state == ISSUE_LO || state == ISSUE_HI;
    ctr_atomic_o = state == ISSUE_LO;
    busy_o = state != IDLE;
    rsp_valid_o = state == RESP ? grant : '0;
    rsp_err_o = state == RESP && err;
    rsp_data_o = (state == RESP && !err) ? {hi, lo} : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant <= '0;
      gidx <= '0;
      rr <= '0;
      lo <= '0;
      hi <= '0;
      timer <= '0;
      err <= 1'b0;
    end else begin
      if (state == IDLE && any) begin
        grant <= pick_grant;
        gidx <= pick_idx;
      end
      if (ctr_req_o) timer <= '0;
      if (waiting && !ctr_ack_i) begin
        timer <= timer + TW'(1);
        if (tmo) err <= 1'b1;
      end
      if (state == WAIT_LO && ctr_ack_i) lo <= ctr_data_i;
      if (state == WAIT_HI && ctr_ack_i) hi <= ctr_data_i;
      if (state == RESP) begin
        err <= 1'b0;
        rr <= gidx == IW'(NREQ - 1) ? '0 : gidx + IW'(1);
      end
    end
  end
endmodule
